// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr
// Round-robin arbiter giving NUM_CORES cores shared access to one single-port
// synchronous RAM. A core may hold the bus for up to MAX_LOCK consecutive
// grants by keeping its lock bit high. Reads are tagged with the granted core
// index and delayed by RD_LAT cycles, so each core can see when mem_q carries
// its data.
//
// Ports:
//   CLK       system clock
//   rst       asynchronous, active-high reset
//   req       per-core access request (level)
//   wren_in   per-core write enable, sampled together with req
//   lock      per-core request to keep the grant on the next cycle
//   addr_in   packed per-core addresses, core i at [i*ADDR_W +: ADDR_W]
//   wdata_in  packed per-core write data, core i at [i*DATA_W +: DATA_W]
//   gnt       one-hot grant, combinational in the request cycle
//   mem_addr  RAM address (granted core's address, 0 when idle)
//   mem_data  RAM write data (granted core's data, 0 when idle)
//   mem_wren  RAM write enable (granted core's wren, 0 when idle)
//   mem_q     RAM read data
//   rdata     mem_q broadcast to all cores
//   rvalid    one-hot; marks the core whose read data is on rdata this cycle
module mem_arbiter_rr #(
  parameter int NUM_CORES = 2,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int RD_LAT    = 1,
  parameter int MAX_LOCK  = 4
) (
  input  logic                          CLK,
  input  logic                          rst,
  input  logic [NUM_CORES-1:0]          req,
  input  logic [NUM_CORES-1:0]          wren_in,
  input  logic [NUM_CORES-1:0]          lock,
  input  logic [NUM_CORES*ADDR_W-1:0]   addr_in,
  input  logic [NUM_CORES*DATA_W-1:0]   wdata_in,
  output logic [NUM_CORES-1:0]          gnt,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_data,
  output logic                          mem_wren,
  input  logic [DATA_W-1:0]             mem_q,
  output logic [DATA_W-1:0]             rdata,
  output logic [NUM_CORES-1:0]          rvalid
);

  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  // lock_cnt counts grants already taken under lock; renewing is allowed
  // only while it is below this limit, so one core holds at most MAX_LOCK.
  localparam logic [3:0] LOCK_LIMIT = 4'(MAX_LOCK - 1);

  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  owner;
  logic              locked_valid;
  logic [3:0]        lock_cnt;

  logic [RD_LAT-1:0] tag_vld;
  logic [IDX_W-1:0]  tag_idx [RD_LAT];

  logic              any_gnt;
  logic [IDX_W-1:0]  g_idx;
  logic [IDX_W-1:0]  cand;

  // Grant selection: a live lock wins while its owner still requests;
  // otherwise scan req cyclically starting at rr_ptr.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path
    // leaves it unassigned, which would infer a latch.
    any_gnt = 1'b0;
    g_idx   = '0;
    cand    = '0;
    if (!rst) begin
      if (locked_valid && req[owner]) begin
        any_gnt = 1'b1;
        g_idx   = owner;
      end else begin
        for (int k = 0; k < NUM_CORES; k++) begin
          cand = IDX_W'((int'(rr_ptr) + k) % NUM_CORES);
          if (!any_gnt && req[cand]) begin
            any_gnt = 1'b1;
            g_idx   = cand;
          end
        end
      end
    end
  end

  // Datapath mux: only the granted core's fields reach the RAM.
  always_comb begin
    gnt      = '0;
    mem_addr = '0;
    mem_data = '0;
    mem_wren = 1'b0;
    if (any_gnt) begin
      gnt      = NUM_CORES'(1) << g_idx;
      mem_addr = addr_in[int'(g_idx)*ADDR_W +: ADDR_W];
      mem_data = wdata_in[int'(g_idx)*DATA_W +: DATA_W];
      mem_wren = wren_in[g_idx];
    end
  end

  // Round-robin pointer and bounded lock bookkeeping.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state is updated with non-blocking assignments so
      // every register samples pre-edge values regardless of block order.
      rr_ptr       <= '0;
      owner        <= '0;
      locked_valid <= 1'b0;
      lock_cnt     <= '0;
    end else if (any_gnt) begin
      rr_ptr <= IDX_W'((int'(g_idx) + 1) % NUM_CORES);
      if (lock[g_idx] && lock_cnt < LOCK_LIMIT) begin
        locked_valid <= 1'b1;
        owner        <= g_idx;
        lock_cnt     <= lock_cnt + 1'b1;
      end else begin
        locked_valid <= 1'b0;
        lock_cnt     <= '0;
      end
    end else begin
      locked_valid <= 1'b0;
      lock_cnt     <= '0;
    end
  end

  // Read-tag pipeline: one stage per cycle of RAM read latency. The last
  // stage lines up with the cycle in which mem_q holds the read data.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      // NOTE: this small tag array is reset, unlike a RAM, because a stale
      // valid bit surviving reset would fire a spurious rvalid.
      tag_vld <= '0;
      for (int i = 0; i < RD_LAT; i++) tag_idx[i] <= '0;
    end else begin
      tag_vld[0] <= any_gnt && !mem_wren;
      tag_idx[0] <= g_idx;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_idx[i] <= tag_idx[i-1];
      end
    end
  end

  assign rvalid = tag_vld[RD_LAT-1] ? (NUM_CORES'(1) << tag_idx[RD_LAT-1]) : '0;
  assign rdata  = mem_q;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// tb_mem_arbiter_rr
// Drives mem_arbiter_rr (4 cores, 2-cycle read latency) with directed and
// random traffic. A behavioural RAM answers the arbiter's accesses; a
// reference model predicts grants and mux outputs, and pushes expected read
// returns into a scoreboard queue that an independent monitor drains
// whenever rvalid is due or seen.
module tb_mem_arbiter_rr;

  localparam int N        = 4;
  localparam int AW       = 8;
  localparam int DW       = 8;
  localparam int RD_LAT   = 2;
  localparam int MAX_LOCK = 4;

  logic              CLK;
  logic              rst;
  logic [N-1:0]      req, wren_in, lock;
  logic [N*AW-1:0]   addr_in;
  logic [N*DW-1:0]   wdata_in;
  logic [N-1:0]      gnt;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_data;
  logic              mem_wren;
  logic [DW-1:0]     mem_q;
  logic [DW-1:0]     rdata;
  logic [N-1:0]      rvalid;

  mem_arbiter_rr #(
    .NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT), .MAX_LOCK(MAX_LOCK)
  ) dut (
    .CLK(CLK), .rst(rst), .req(req), .wren_in(wren_in), .lock(lock),
    .addr_in(addr_in), .wdata_in(wdata_in), .gnt(gnt), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q), .rdata(rdata),
    .rvalid(rvalid)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  // ---------------- behavioural synchronous RAM ----------------
  function automatic logic [DW-1:0] init_val(input int i);
    return (i == 5) ? 8'hA7 : 8'(i * 37 + 5);
  endfunction

  logic          ram_init;
  logic [DW-1:0] ram    [256];
  logic [DW-1:0] q_pipe [RD_LAT];

  always @(posedge CLK) begin
    if (ram_init) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
    end else if (mem_wren) begin
      ram[mem_addr] <= mem_data;
    end
    q_pipe[0] <= ram[mem_addr];
    for (int i = 1; i < RD_LAT; i++) q_pipe[i] <= q_pipe[i-1];
  end
  assign mem_q = q_pipe[RD_LAT-1];

  // ---------------- reference model ----------------
  typedef struct {
    int            core;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t          sb [$];
  logic [DW-1:0] exp_ram [256];
  int            m_rr, m_owner, m_cnt;
  bit            m_locked;

  function automatic void model_reset();
    m_rr = 0; m_owner = 0; m_cnt = 0; m_locked = 0;
  endfunction

  // Which core wins this cycle, or -1 when nobody requests.
  function automatic int model_grant(input logic [N-1:0] r);
    if (m_locked && r[m_owner]) return m_owner;
    for (int k = 0; k < N; k++)
      if (r[(m_rr + k) % N]) return (m_rr + k) % N;
    return -1;
  endfunction

  function automatic void model_advance(input int g, input logic [N-1:0] l);
    if (g < 0) begin
      m_locked = 0; m_cnt = 0;
    end else begin
      m_rr = (g + 1) % N;
      if (l[g] && m_cnt + 1 < MAX_LOCK) begin
        m_locked = 1; m_owner = g; m_cnt = m_cnt + 1;
      end else begin
        m_locked = 0; m_cnt = 0;
      end
    end
  endfunction

  // One bus cycle: drive just after the edge, check mid-cycle, predict.
  task automatic do_cycle(input logic [N-1:0] r, input logic [N-1:0] w,
                          input logic [N-1:0] l, input logic [N*AW-1:0] a,
                          input logic [N*DW-1:0] d);
    int            g;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic          ew;
    req = r; wren_in = w; lock = l; addr_in = a; wdata_in = d;
    @(negedge CLK);
    g  = model_grant(r);
    ea = (g >= 0) ? a[g*AW +: AW] : '0;
    ed = (g >= 0) ? d[g*DW +: DW] : '0;
    ew = (g >= 0) ? w[g] : 1'b0;
    check("gnt", 32'(gnt), (g >= 0) ? (32'd1 << g) : 32'd0);
    check("mem_addr", 32'(mem_addr), 32'(ea));
    check("mem_data", 32'(mem_data), 32'(ed));
    check("mem_wren", 32'(mem_wren), 32'(ew));
    if (g >= 0) begin
      if (ew) exp_ram[ea] = ed;
      else    sb.push_back('{core: g, data: exp_ram[ea], due: cyc + RD_LAT});
    end
    model_advance(g, l);
    @(posedge CLK); #1;
  endtask

  // Reset pulse; outputs must drop immediately and pending reads vanish.
  task automatic apply_reset();
    rst = 1'b1;
    req = '1; wren_in = '1; lock = '0;
    #1;
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_wren", 32'(mem_wren), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_data", 32'(mem_data), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    sb.delete();
    model_reset();
    repeat (2) @(posedge CLK);
    #1 rst = 1'b0;
  endtask

  function automatic logic [N*AW-1:0] pk(input logic [7:0] v0, v1, v2, v3);
    return {v3, v2, v1, v0};
  endfunction

  // ---------------- monitor ----------------
  always @(negedge CLK) begin
    if (!rst) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        exp_t e;
        e = sb.pop_front();
        check("rvalid", 32'(rvalid), 32'd1 << e.core);
        check("rdata", 32'(rdata), 32'(e.data));
      end else begin
        check("rvalid_idle", 32'(rvalid), 32'd0);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [N-1:0]    r, w, l;
    logic [N*AW-1:0] a;
    logic [N*DW-1:0] d;

    rst = 1'b1; ram_init = 1'b1;
    req = '0; wren_in = '0; lock = '0; addr_in = '0; wdata_in = '0;
    for (int i = 0; i < 256; i++) exp_ram[i] = init_val(i);
    model_reset();
    @(posedge CLK); #1 ram_init = 1'b0;
    apply_reset();

    // Two cores alternate under plain round-robin.
    repeat (4) do_cycle(4'b0011, 4'b0000, 4'b0000, pk(8'h01, 8'h02, 8'h03, 8'h04), '0);

    // Sparse request pattern wraps the pointer.
    apply_reset();
    repeat (3) do_cycle(4'b1010, 4'b0000, 4'b0000, pk(8'h11, 8'h12, 8'h13, 8'h14), '0);

    // Core 0 locks: four grants, forced release to core 1, then back.
    apply_reset();
    repeat (6) do_cycle(4'b0011, 4'b0000, 4'b0001, pk(8'h07, 8'h08, 8'h00, 8'h00), '0);

    // Core 1 reads the preloaded word; then a lone write returns nothing.
    do_cycle(4'b0010, 4'b0000, 4'b0000, pk(8'h00, 8'h05, 8'h00, 8'h00), '0);
    do_cycle(4'b0001, 4'b0001, 4'b0000, pk(8'h20, 8'h00, 8'h00, 8'h00), pk(8'h55, 8'h00, 8'h00, 8'h00));

    // Core 0 writes while core 1 reads the same address, then core 1 re-reads.
    repeat (2) do_cycle(4'b0011, 4'b0001, 4'b0000, pk(8'h10, 8'h10, 8'h00, 8'h00), pk(8'h3C, 8'hEE, 8'h00, 8'h00));
    do_cycle(4'b0010, 4'b0000, 4'b0000, pk(8'h00, 8'h10, 8'h00, 8'h00), '0);
    repeat (3) do_cycle('0, '0, '0, '0, '0);

    // Reset one cycle after a granted read: its return must never appear.
    do_cycle(4'b0100, 4'b0000, 4'b0000, pk(8'h00, 8'h00, 8'h05, 8'h00), '0);
    apply_reset();
    do_cycle(4'b0110, 4'b0000, 4'b0000, pk(8'h00, 8'h01, 8'h02, 8'h00), '0);
    repeat (4) do_cycle('0, '0, '0, '0, '0);

    // Random traffic over a small address window so reads hit earlier writes.
    for (int n = 0; n < 400; n++) begin
      r = N'($urandom);
      w = N'($urandom);
      l = ($urandom_range(0, 2) == 0) ? '0 : N'($urandom);
      for (int i = 0; i < N; i++) a[i*AW +: AW] = 8'($urandom_range(0, 15));
      d = ($urandom);
      do_cycle(r, w, l, a, d);
    end

    repeat (RD_LAT + 3) do_cycle('0, '0, '0, '0, '0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
